video_timing: RTL
=================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter H_TOTAL, 200, pixels per line (hpos counts 0..H_TOTAL-1), SHALL be at most 256.
REQ-002 Parameter H_ACTIVE, 160, visible pixels per line; HSYNC_START, 170; HSYNC_END, 182 (exclusive) SHALL define hsync.
REQ-003 Parameter V_TOTAL, 112, lines per frame (vpos counts 0..V_TOTAL-1), SHALL be at most 128.
REQ-004 Parameter V_ACTIVE, 100, visible lines; VSYNC_START, 105; VSYNC_END, 108 (exclusive) SHALL define vsync.
REQ-005 Ports SHALL be, in order:
  clk  in  1  system clock, all logic on rising edge
  reset  in  1  asynchronous, active-low reset
  cs  in  1  register select
  rw  in  1  1=write, 0=read
  addr  in  4  register address
  di  in  8  write data
  dout  out  8  read data, registered
  hpos  out  8  current pixel column
  vpos  out  7  current line
  hsync  out  1  active-high horizontal sync
  vsync  out  1  active-high vertical sync
  display_on  out  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE
  pix_en  out  1  one-clk strobe on the clock before each pixel advance
  irq  out  1  level interrupt request

Function
REQ-006 A 2-bit phase counter SHALL count 0..3 while CTRL.en=1; pix_en SHALL equal (phase==3)&CTRL.en, so one pixel spans exactly 4 clk (matching the 4-state downstream sprite pipeline).
REQ-007 On an edge with pix_en=1, hpos SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vpos SHALL increment; vpos at V_TOTAL-1 SHALL wrap to 0.
REQ-008 hsync, vsync, display_on SHALL be registered, updated on the same edge as hpos/vpos and consistent with the new hpos/vpos values (no extra cycle of skew).
REQ-009 hsync=1 iff HSYNC_START<=hpos<HSYNC_END; vsync=1 iff VSYNC_START<=vpos<VSYNC_END.
REQ-010 CTRL.en=0 SHALL freeze phase, hpos, vpos and all sync outputs and hold pix_en=0; re-enable SHALL resume from phase 0 on the held position.
REQ-011 Registers (addr): 0 CTRL {bit0 en, bit1 raster_ie, bit2 vblank_ie}; 1 STAT {bit0 raster_pend, bit1 vblank_pend, bit2 in_vblank RO}; 2 LINECMP [6:0]; 3 FRAME [7:0] RO; 4 VPOS RO; 5 HPOS RO; others read 0, writes ignored.
REQ-012 Write: cs&rw at an edge SHALL update the register; STAT pending bits SHALL be write-1-to-clear; writes to RO registers SHALL be ignored.
REQ-013 Read: cs&~rw at an edge SHALL load dout with the addressed value sampled at that edge (1-clk latency); dout SHALL hold otherwise.
REQ-014 raster_pend SHALL set on the advance edge where vpos becomes LINECMP and hpos becomes 0; LINECMP>=V_TOTAL SHALL never fire.
REQ-015 vblank_pend SHALL set on the advance edge where vpos becomes V_ACTIVE and hpos becomes 0.
REQ-016 Simultaneous set and write-1-clear of the same pending bit SHALL leave it set.
REQ-017 irq SHALL be registered and equal (raster_pend&raster_ie)|(vblank_pend&vblank_ie) one clk after the pending/enable change.
REQ-018 FRAME SHALL increment, modulo 256, on each advance edge where vpos wraps V_TOTAL-1 -> 0.
REQ-019 in_vblank SHALL read 1 iff vpos>=V_ACTIVE.

Reset
REQ-020 reset low SHALL immediately force: phase=0, hpos=0, vpos=0, FRAME=0, LINECMP=0, CTRL=8'h01, STAT pending=0, dout=0, hsync=0, vsync=0, display_on=0, pix_en=0, irq=0.
REQ-021 display_on SHALL become 1 on the first advance edge after reset release; reset asserted mid-frame or mid-write SHALL discard all state, no partial write retained.

Verification
REQ-022 Release reset, run 4*200*112 clk -> pix_en every 4th clk, hpos 0..199, vpos 0..111, FRAME=1, hsync high 12 pixels per line, vsync high 3 lines.
REQ-023 Write LINECMP=50, CTRL=8'h03 -> irq=1 one clk after vpos becomes 50 at hpos 0; write STAT=8'h01 -> irq=0 next clk.
REQ-024 CTRL=8'h05, wait to vpos=100 -> vblank_pend=1, irq=1, in_vblank=1; clear on the same edge a new set occurs -> bit stays 1.
REQ-025 Write CTRL=0 at hpos=37 -> hpos/vpos frozen, pix_en=0 for 1000 clk; CTRL=1 -> hpos=38 after 4 clk.
REQ-026 Read addr 5 at hpos=120 -> dout=8'd120 one clk later; read addr 9 -> dout=0; assert reset at vpos=60 -> all outputs 0 immediately.

Source files
------------

// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster timing generator with 4-clk pixel strobe, sync outputs and register block
module video_timing #(
  parameter int H_TOTAL     = 200,
  parameter int H_ACTIVE    = 160,
  parameter int HSYNC_START = 170,
  parameter int HSYNC_END   = 182,
  parameter int V_TOTAL     = 112,
  parameter int V_ACTIVE    = 100,
  parameter int VSYNC_START = 105,
  parameter int VSYNC_END   = 108
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rw,
  input  logic [3:0] addr,
  input  logic [7:0] di,
  output logic [7:0] dout,
  output logic [7:0] hpos,
  output logic [6:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       pix_en,
  output logic       irq
);

  logic [1:0] r_phase;
  logic [7:0] r_hpos;
  logic [6:0] r_vpos;
  logic [7:0] r_frame;
  logic [6:0] r_linecmp;
  logic       r_en, r_raster_ie, r_vblank_ie;
  logic       r_raster_pend, r_vblank_pend;
  logic       r_hsync, r_vsync, r_display_on, r_irq;
  logic [7:0] r_dout;

  logic       w_adv, w_hwrap, w_vwrap, w_wr, w_rd, w_in_vblank;
  logic       w_raster_set, w_vblank_set;
  logic       w_raster_clr, w_vblank_clr;
  logic [7:0] w_hnext;
  logic [6:0] w_vnext;
  logic [7:0] w_rdata;
  logic       w_unused;

  assign w_adv       = r_en && (r_phase == 2'd3);
  assign w_hwrap     = (r_hpos == 8'(H_TOTAL - 1));
  assign w_vwrap     = (r_vpos == 7'(V_TOTAL - 1));
  assign w_hnext     = w_hwrap ? 8'd0 : r_hpos + 8'd1;
  assign w_vnext     = w_hwrap ? (w_vwrap ? 7'd0 : r_vpos + 7'd1) : r_vpos;
  assign w_wr        = cs && rw;
  assign w_rd        = cs && !rw;
  assign w_in_vblank = (r_vpos >= 7'(V_ACTIVE));
  assign w_unused    = di[7];

  // Line events fire on the advance that lands on column 0 of the target line.
  assign w_raster_set = w_adv && w_hwrap && (w_vnext == r_linecmp);
  assign w_vblank_set = w_adv && w_hwrap && (w_vnext == 7'(V_ACTIVE));
  assign w_raster_clr = w_wr && (addr == 4'd1) && di[0];
  assign w_vblank_clr = w_wr && (addr == 4'd1) && di[1];

  always_comb begin
    w_rdata = 8'd0;
    case (addr)
      4'd0:    w_rdata = {5'd0, r_vblank_ie, r_raster_ie, r_en};
      4'd1:    w_rdata = {5'd0, w_in_vblank, r_vblank_pend, r_raster_pend};
      4'd2:    w_rdata = {1'b0, r_linecmp};
      4'd3:    w_rdata = r_frame;
      4'd4:    w_rdata = {1'b0, r_vpos};
      4'd5:    w_rdata = r_hpos;
      default: w_rdata = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase       <= 2'd0;
      r_hpos        <= 8'd0;
      r_vpos        <= 7'd0;
      r_frame       <= 8'd0;
      r_linecmp     <= 7'd0;
      r_en          <= 1'b1;
      r_raster_ie   <= 1'b0;
      r_vblank_ie   <= 1'b0;
      r_raster_pend <= 1'b0;
      r_vblank_pend <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_display_on  <= 1'b0;
      r_irq         <= 1'b0;
      r_dout        <= 8'd0;
    end else begin
      // Disabled phase parks at 0 so a re-enable always yields a full pixel period.
      r_phase <= r_en ? r_phase + 2'd1 : 2'd0;
      if (w_adv) begin
        r_hpos       <= w_hnext;
        r_vpos       <= w_vnext;
        r_hsync      <= (w_hnext >= 8'(HSYNC_START)) && (w_hnext < 8'(HSYNC_END));
        r_vsync      <= (w_vnext >= 7'(VSYNC_START)) && (w_vnext < 7'(VSYNC_END));
        r_display_on <= (w_hnext < 8'(H_ACTIVE)) && (w_vnext < 7'(V_ACTIVE));
        if (w_hwrap && w_vwrap) r_frame <= r_frame + 8'd1;
      end
      r_irq         <= (r_raster_pend && r_raster_ie) || (r_vblank_pend && r_vblank_ie);
      r_raster_pend <= w_raster_set || (r_raster_pend && !w_raster_clr);
      r_vblank_pend <= w_vblank_set || (r_vblank_pend && !w_vblank_clr);
      if (w_wr && (addr == 4'd0)) {r_vblank_ie, r_raster_ie, r_en} <= di[2:0];
      if (w_wr && (addr == 4'd2)) r_linecmp <= di[6:0];
      if (w_rd) r_dout <= w_rdata;
    end
  end

  assign dout       = r_dout;
  assign hpos       = r_hpos;
  assign vpos       = r_vpos;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign display_on = r_display_on;
  assign pix_en     = w_adv;
  assign irq        = r_irq;

endmodule
